// File: rtl/tristate_port_pkg.sv
// tristate_port shared types and constants.
// FSM encoding, counter widths and parameter limits.
package tristate_port_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TURN = 1'b1
  } state_e;

  localparam int CNT_W    = 4;
  localparam int ARM_W    = 3;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int TURN_MAX = 15;

endpackage

// File: rtl/tristate_sync.sv
// WIDTH-wide, STAGES-deep input synchroniser.
// Async active-low reset, reusable by other pad blocks.
module tristate_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        ff_q[s] <= '0;
      end
    end else begin
      ff_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        ff_q[s] <= ff_q[s-1];
      end
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/tristate_port.sv
// Registered tristate pad wrapper with guarded turnaround,
// input synchroniser and sticky edge-pending interrupts.
module tristate_port
  import tristate_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dir,
  input  logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] o_in,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_irq_clear,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_irq,
  output logic [WIDTH-1:0] o_oe,
  output logic             o_busy,
  inout  tri   [WIDTH-1:0] io
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("tristate_port: SYNC_STAGES out of range");
  end
  if (TURN_CYCLES < 0 || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
    $error("tristate_port: TURN_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES);
  localparam logic [ARM_W-1:0] ARM_END = ARM_W'(SYNC_STAGES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] dir_prev_q;
  logic [WIDTH-1:0] tpend_q, tpend_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] rise, fall, set;
  logic             armed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign io[g] = oe_q[g] ? out_q[g] : 1'bz;
  end

  assign req = i_dir & ~dir_prev_q;

  // Dropped directions release at once; new drives wait out the guard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q & i_dir;
    tpend_d = tpend_q & i_dir;
    if (TURN_CYCLES == 0) begin
      oe_d    = oe_d | req;
      tpend_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
            tpend_d = tpend_d | req;
          end
        end
        ST_TURN: begin
          if (|req) begin
            cnt_d   = TURN_LD;
            tpend_d = tpend_d | req;
          end else if (cnt_q == '0) begin
            oe_d    = oe_d | tpend_d;
            tpend_d = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  tristate_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (io),
    .q_o   (sync_q)
  );

  assign armed  = (arm_q == ARM_END);
  assign arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;
  assign set    = {WIDTH{armed}} & ~oe_q &
                  ((rise & i_rise_en) | (fall & i_fall_en));
  assign pend_d = (pend_q & ~i_irq_clear) | set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_q      <= '0;
      oe_q       <= '0;
      dir_prev_q <= '0;
      tpend_q    <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      arm_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= i_out;
      oe_q       <= oe_d;
      dir_prev_q <= i_dir;
      tpend_q    <= tpend_d;
      prev_q     <= sync_q;
      pend_q     <= pend_d;
      arm_q      <= arm_d;
    end
  end

  assign o_in      = sync_q;
  assign o_pending = pend_q;
  assign o_irq     = |pend_q;
  assign o_oe      = oe_q;
  assign o_busy    = (state_q == ST_TURN);

endmodule

// File: tb/tb_tristate_port.sv
// Directed bench for tristate_port: turnaround table,
// reset, edge-pending and reset-mid-turn sequences.
module tb_tristate_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_dir = '0;
  logic [7:0] i_out = '0;
  logic [7:0] i_rise_en = '0;
  logic [7:0] i_fall_en = '0;
  logic [7:0] i_irq_clear = '0;
  logic [7:0] o_in, o_pending, o_oe;
  logic       o_irq, o_busy;
  logic [7:0] tb_en = 8'hFF;
  logic [7:0] tb_val = 8'hFF;
  tri   [7:0] io;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] dir;
    logic [7:0] out;
    logic [7:0] oe;
    logic       busy;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  tristate_port #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .TURN_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_dir       (i_dir),
    .i_out       (i_out),
    .o_in        (o_in),
    .i_rise_en   (i_rise_en),
    .i_fall_en   (i_fall_en),
    .i_irq_clear (i_irq_clear),
    .o_pending   (o_pending),
    .o_irq       (o_irq),
    .o_oe        (o_oe),
    .o_busy      (o_busy),
    .io          (io)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    i_irq_clear = 8'hFF;
    tick();
    i_irq_clear = 8'h00;
  endtask

  initial begin
    tbl = '{
      '{8'h00, 8'h05, 8'h00, 1'b0},
      '{8'h0F, 8'h05, 8'h00, 1'b1},
      '{8'h0F, 8'h05, 8'h00, 1'b1},
      '{8'h0F, 8'h05, 8'h0F, 1'b0},
      '{8'h0F, 8'h05, 8'h0F, 1'b0},
      '{8'h00, 8'h05, 8'h00, 1'b0},
      '{8'h01, 8'h05, 8'h00, 1'b1},
      '{8'h11, 8'h05, 8'h00, 1'b1},
      '{8'h11, 8'h05, 8'h00, 1'b1},
      '{8'h11, 8'h05, 8'h11, 1'b0},
      '{8'h00, 8'h05, 8'h00, 1'b0},
      '{8'h01, 8'h05, 8'h00, 1'b1},
      '{8'h11, 8'h05, 8'h00, 1'b1},
      '{8'h10, 8'h05, 8'h00, 1'b1},
      '{8'h10, 8'h05, 8'h10, 1'b0},
      '{8'h10, 8'h05, 8'h10, 1'b0},
      '{8'h1F, 8'h05, 8'h10, 1'b1},
      '{8'h1F, 8'h05, 8'h10, 1'b1},
      '{8'h1F, 8'h05, 8'h1F, 1'b0},
      '{8'h00, 8'h05, 8'h00, 1'b0}
    };

    // reset with pins pulled high, edges enabled
    i_rise_en = 8'hFF;
    i_fall_en = 8'hFF;
    repeat (3) tick();
    chk("rst_oe", o_oe, 8'h00);
    chk("rst_busy", {7'd0, o_busy}, 8'h00);
    chk("rst_in", o_in, 8'h00);
    chk("rst_pend", o_pending, 8'h00);
    chk("rst_irq", {7'd0, o_irq}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("in_1clk", o_in, 8'h00);
    tick();
    chk("in_2clk", o_in, 8'hFF);
    repeat (4) tick();
    chk("no_spur_pend", o_pending, 8'h00);
    chk("no_spur_irq", {7'd0, o_irq}, 8'h00);

    // turnaround table
    i_rise_en = 8'h00;
    i_fall_en = 8'h00;
    tb_en = 8'hE0;
    tb_val = 8'hA0;
    repeat (3) tick();
    clear_all();
    for (int i = 0; i < 20; i++) begin
      i_dir = tbl[i].dir;
      i_out = tbl[i].out;
      tick();
      chk($sformatf("tbl%0d_oe", i), o_oe, tbl[i].oe);
      chk($sformatf("tbl%0d_busy", i), {7'd0, o_busy},
          {7'd0, tbl[i].busy});
      if (i == 3) begin
        chk("io_low_nib", {4'd0, io[3:0]}, 8'h05);
      end
    end

    // all bits on, then all off in one clock
    tb_en = 8'h00;
    i_dir = 8'hFF;
    repeat (3) tick();
    chk("all_on", o_oe, 8'hFF);
    i_dir = 8'h00;
    tick();
    chk("all_off_oe", o_oe, 8'h00);
    chk("all_off_busy", {7'd0, o_busy}, 8'h00);

    // pin 2 input edges
    tb_en = 8'h04;
    tb_val = 8'h00;
    repeat (4) tick();
    clear_all();
    chk("p2_idle", o_pending, 8'h00);
    i_rise_en = 8'h04;
    tb_val = 8'h04;
    tick();
    chk("p2_in_1clk", o_in & 8'h04, 8'h00);
    tick();
    chk("p2_in_2clk", o_in & 8'h04, 8'h04);
    chk("p2_pend_early", o_pending, 8'h00);
    tick();
    chk("p2_pend", o_pending, 8'h04);
    chk("p2_irq", {7'd0, o_irq}, 8'h01);
    i_irq_clear = 8'h04;
    tick();
    i_irq_clear = 8'h00;
    chk("p2_cleared", o_pending, 8'h00);
    chk("p2_irq_off", {7'd0, o_irq}, 8'h00);
    tb_val = 8'h00;
    repeat (3) tick();
    tb_val = 8'h04;
    repeat (3) tick();
    chk("p2_rise2", o_pending, 8'h04);
    tb_val = 8'h00;
    repeat (3) tick();
    chk("p2_fall_masked", o_pending, 8'h04);
    tb_val = 8'h04;
    tick();
    tick();
    i_irq_clear = 8'h04;
    tick();
    i_irq_clear = 8'h00;
    chk("p2_set_wins", o_pending, 8'h04);
    i_fall_en = 8'h04;
    clear_all();
    chk("p2_clr2", o_pending, 8'h00);
    tb_val = 8'h00;
    repeat (3) tick();
    chk("p2_fall", o_pending, 8'h04);

    // driven bit never sets pending
    i_rise_en = 8'hFF;
    i_fall_en = 8'hFF;
    tb_en = 8'h00;
    repeat (3) tick();
    clear_all();
    i_dir = 8'h01;
    i_out = 8'h01;
    repeat (7) tick();
    chk("drv_io0", {7'd0, io[0]}, 8'h01);
    chk("drv_in0", o_in & 8'h01, 8'h01);
    chk("drv_no_pend", o_pending & 8'h01, 8'h00);

    // reset during turnaround
    i_rise_en = 8'h00;
    i_fall_en = 8'h00;
    i_dir = 8'hF1;
    tick();
    chk("mid_busy", {7'd0, o_busy}, 8'h01);
    chk("mid_oe", o_oe, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oe", o_oe, 8'h00);
    chk("arst_busy", {7'd0, o_busy}, 8'h00);
    i_dir = 8'h00;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_oe", o_oe, 8'h00);
    chk("post_busy", {7'd0, o_busy}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
